// File: rtl/instr_field_reg.sv
// Instruction-field stage: two-entry skid buffer between fetch and decode, splitting the head word into MIPS fields.
// Optional perf counters (IssueCount/StallCount) are built when IR_PERF_CNT_EN is defined.
module instr_field_reg #(
    parameter int unsigned PC_W   = 32,
    parameter int unsigned PC_INC = 4
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Flush,
    input  logic            IR_InValid,
    output logic            IR_InReady,
    input  logic [31:0]     IR_Instr,
    input  logic [PC_W-1:0] IR_PC,
    output logic            IR_OutValid,
    input  logic            IR_OutReady,
    output logic [5:0]      Opcode,
    output logic [4:0]      Rs,
    output logic [4:0]      Rt,
    output logic [4:0]      Rd,
    output logic [4:0]      Shamt,
    output logic [5:0]      Funct,
    output logic [15:0]     Imm16,
    output logic            ImmZeroExt,
    output logic [PC_W-1:0] PCPlus4
`ifdef IR_PERF_CNT_EN
    ,
    output logic [31:0]     IssueCount,
    output logic [31:0]     StallCount
`endif
);

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned CNT_W   = 32;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t state;
    entry_t head;
    entry_t skid;
    entry_t in_entry;
    logic   accept;
    logic   pop;

    assign in_entry = {IR_Instr, IR_PC};
    assign accept   = IR_InValid & IR_InReady;
    assign pop      = IR_OutValid & IR_OutReady;

    // andi / ori / xori take a zero-extended immediate; everything else sign-extends
    function automatic logic is_zero_ext_op(input logic [5:0] op);
        return (op == 6'h0C) || (op == 6'h0D) || (op == 6'h0E);
    endfunction

    // Buffer state machine; ready/valid are registered decodes of the next state
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= ST_EMPTY;
            head        <= '0;
            skid        <= '0;
            IR_InReady  <= 1'b1;
            IR_OutValid <= 1'b0;
        end else if (Flush) begin
            state       <= ST_EMPTY;
            IR_InReady  <= 1'b1;
            IR_OutValid <= 1'b0;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        head        <= in_entry;
                        state       <= ST_ONE;
                        IR_OutValid <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && pop) begin
                        head <= in_entry;
                    end else if (accept) begin
                        skid       <= in_entry;
                        state      <= ST_TWO;
                        IR_InReady <= 1'b0;
                    end else if (pop) begin
                        state       <= ST_EMPTY;
                        IR_OutValid <= 1'b0;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        head       <= skid;
                        state      <= ST_ONE;
                        IR_InReady <= 1'b1;
                    end
                end
                default: begin
                    state       <= ST_EMPTY;
                    IR_InReady  <= 1'b1;
                    IR_OutValid <= 1'b0;
                end
            endcase
        end
    end

    assign Opcode     = head.instr[31:26];
    assign Rs         = head.instr[25:21];
    assign Rt         = head.instr[20:16];
    assign Rd         = head.instr[15:11];
    assign Shamt      = head.instr[10:6];
    assign Funct      = head.instr[5:0];
    assign Imm16      = head.instr[15:0];
    assign ImmZeroExt = is_zero_ext_op(head.instr[31:26]);
    assign PCPlus4    = head.pc + PC_W'(PC_INC);

`ifdef IR_PERF_CNT_EN
    // Pops ignored under Flush are not issues; stalls count whenever the head waits
    always_ff @(posedge Clk) begin
        if (Reset) begin
            IssueCount <= '0;
            StallCount <= '0;
        end else begin
            if (pop && !Flush) begin
                IssueCount <= IssueCount + CNT_W'(1);
            end
            if (IR_OutValid && !IR_OutReady) begin
                StallCount <= StallCount + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_field_reg.sv
// Directed bench for instr_field_reg: reset state, field split, skid/backpressure, flush, wrap, mid-run reset.
module tb_instr_field_reg;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Flush;
    logic        IR_InValid;
    logic        IR_InReady;
    logic [31:0] IR_Instr;
    logic [31:0] IR_PC;
    logic        IR_OutValid;
    logic        IR_OutReady;
    logic [5:0]  Opcode;
    logic [4:0]  Rs, Rt, Rd, Shamt;
    logic [5:0]  Funct;
    logic [15:0] Imm16;
    logic        ImmZeroExt;
    logic [31:0] PCPlus4;
`ifdef IR_PERF_CNT_EN
    logic [31:0] IssueCount;
    logic [31:0] StallCount;
`endif

    int total = 0;
    int bad   = 0;

    instr_field_reg #(.PC_W(32), .PC_INC(4)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Flush       (Flush),
        .IR_InValid  (IR_InValid),
        .IR_InReady  (IR_InReady),
        .IR_Instr    (IR_Instr),
        .IR_PC       (IR_PC),
        .IR_OutValid (IR_OutValid),
        .IR_OutReady (IR_OutReady),
        .Opcode      (Opcode),
        .Rs          (Rs),
        .Rt          (Rt),
        .Rd          (Rd),
        .Shamt       (Shamt),
        .Funct       (Funct),
        .Imm16       (Imm16),
        .ImmZeroExt  (ImmZeroExt),
        .PCPlus4     (PCPlus4)
`ifdef IR_PERF_CNT_EN
        ,
        .IssueCount  (IssueCount),
        .StallCount  (StallCount)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1ns later
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        IR_InValid = v;
        IR_Instr   = instr;
        IR_PC      = pc;
    endtask

    initial begin
        Reset = 1'b1;
        Flush = 1'b0;
        IR_OutReady = 1'b1;
        drive(1'b0, 32'h0, 32'h0);

        // reset
        step();
        step();
        check("rst_valid", 32'(IR_OutValid), 32'd0);
        check("rst_ready", 32'(IR_InReady), 32'd1);
        check("rst_imm", 32'(Imm16), 32'd0);
        check("rst_op", 32'(Opcode), 32'd0);
        check("rst_pc4", PCPlus4, 32'h4);
        check("rst_zext", 32'(ImmZeroExt), 32'd0);
        Reset = 1'b0;

        // addi, single accept from EMPTY
        drive(1'b1, 32'h2008FFFF, 32'h100);
        step();
        check("addi_valid", 32'(IR_OutValid), 32'd1);
        check("addi_op", 32'(Opcode), 32'h08);
        check("addi_rt", 32'(Rt), 32'd8);
        check("addi_imm", 32'(Imm16), 32'hFFFF);
        check("addi_zext", 32'(ImmZeroExt), 32'd0);
        check("addi_pc4", PCPlus4, 32'h104);

        // ori replaces head (accept + pop in ONE)
        drive(1'b1, 32'h350800FF, 32'h104);
        step();
        check("ori_op", 32'(Opcode), 32'h0D);
        check("ori_imm", 32'(Imm16), 32'h00FF);
        check("ori_zext", 32'(ImmZeroExt), 32'd1);
        check("ori_rs", 32'(Rs), 32'd8);

        // add, R-type fields
        drive(1'b1, 32'h012A4020, 32'h108);
        step();
        check("add_op", 32'(Opcode), 32'h00);
        check("add_rs", 32'(Rs), 32'd9);
        check("add_rt", 32'(Rt), 32'd10);
        check("add_rd", 32'(Rd), 32'd8);
        check("add_shamt", 32'(Shamt), 32'd0);
        check("add_funct", 32'(Funct), 32'h20);
        check("add_pc4", PCPlus4, 32'h10C);

        // pop to EMPTY; fields keep the last head
        drive(1'b0, 32'h0, 32'h0);
        step();
        check("empty_valid", 32'(IR_OutValid), 32'd0);
        check("empty_ready", 32'(IR_InReady), 32'd1);
        check("empty_funct", 32'(Funct), 32'h20);

        // backpressure: A, B fill buffer, C held by source
        IR_OutReady = 1'b0;
        drive(1'b1, 32'h31230001, 32'h200);
        step();
        check("bp_a_valid", 32'(IR_OutValid), 32'd1);
        check("bp_a_ready", 32'(IR_InReady), 32'd1);
        drive(1'b1, 32'h39AB1234, 32'h204);
        step();
        check("bp_b_ready", 32'(IR_InReady), 32'd0);
        check("bp_hold_imm", 32'(Imm16), 32'h0001);
        drive(1'b1, 32'h8C440010, 32'h208);
        step();
        check("bp_c_ready", 32'(IR_InReady), 32'd0);
        check("bp_hold_pc4", PCPlus4, 32'h204);
        check("bp_hold_zext", 32'(ImmZeroExt), 32'd1);
        IR_OutReady = 1'b1;
        step();
        check("pop_b_imm", 32'(Imm16), 32'h1234);
        check("pop_b_pc4", PCPlus4, 32'h208);
        check("pop_b_ready", 32'(IR_InReady), 32'd1);
        step();
        check("pop_c_op", 32'(Opcode), 32'h23);
        check("pop_c_imm", 32'(Imm16), 32'h0010);
        check("pop_c_zext", 32'(ImmZeroExt), 32'd0);
        check("pop_c_pc4", PCPlus4, 32'h20C);
        drive(1'b0, 32'h0, 32'h0);
        step();
        check("pop_c_empty", 32'(IR_OutValid), 32'd0);

        // flush from TWO with a word offered in the same cycle
        IR_OutReady = 1'b0;
        drive(1'b1, 32'h11111111, 32'h300);
        step();
        drive(1'b1, 32'h22222222, 32'h304);
        step();
        check("fl_two_ready", 32'(IR_InReady), 32'd0);
        Flush = 1'b1;
        drive(1'b1, 32'h33333333, 32'h308);
        step();
        check("fl_valid", 32'(IR_OutValid), 32'd0);
        check("fl_ready", 32'(IR_InReady), 32'd1);
        check("fl_keep_imm", 32'(Imm16), 32'h1111);
        Flush = 1'b0;
        IR_OutReady = 1'b1;
        drive(1'b0, 32'h0, 32'h0);
        step();
        check("fl_no_ghost", 32'(IR_OutValid), 32'd0);

        // PCPlus4 wraps at 2^32
        drive(1'b1, 32'h24420007, 32'hFFFFFFFC);
        step();
        check("wrap_valid", 32'(IR_OutValid), 32'd1);
        check("wrap_op", 32'(Opcode), 32'h09);
        check("wrap_pc4", PCPlus4, 32'h0);
        drive(1'b0, 32'h0, 32'h0);
        step();

        // reset mid-operation with a full buffer
        IR_OutReady = 1'b0;
        drive(1'b1, 32'hAAAA5555, 32'h400);
        step();
        drive(1'b1, 32'hBBBB6666, 32'h404);
        step();
        Reset = 1'b1;
        step();
        check("mr_valid", 32'(IR_OutValid), 32'd0);
        check("mr_ready", 32'(IR_InReady), 32'd1);
        check("mr_imm", 32'(Imm16), 32'd0);
        check("mr_pc4", PCPlus4, 32'h4);
        Reset = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        step();
        check("mr_stay_empty", 32'(IR_OutValid), 32'd0);

`ifdef IR_PERF_CNT_EN
        // 3 pops and 2 stall cycles after the reset above
        check("pc_rst_issue", IssueCount, 32'd0);
        check("pc_rst_stall", StallCount, 32'd0);
        IR_OutReady = 1'b0;
        drive(1'b1, 32'h00000001, 32'h500);
        step();
        drive(1'b1, 32'h00000002, 32'h504);
        step();
        drive(1'b0, 32'h0, 32'h0);
        step();
        IR_OutReady = 1'b1;
        step();
        step();
        drive(1'b1, 32'h00000003, 32'h508);
        step();
        drive(1'b0, 32'h0, 32'h0);
        step();
        check("pc_issue", IssueCount, 32'd3);
        check("pc_stall", StallCount, 32'd2);
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        check("pc_fl_issue", IssueCount, 32'd3);
        check("pc_fl_stall", StallCount, 32'd2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
